hilo_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit owning the HI/LO register pair for the MIPS datapath.

---
 rtl/hilo_muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Optional build macro HILO_MULDIV_ACCUM_EN adds MADD/MADDU accumulation into {Hi,Lo}.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic             Accum,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negIfWide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               isDiv_r;
  logic               accum_r;
  logic               negRes_r;
  logic               negRem_r;
  logic               divZero_r;
  logic [WIDTH-1:0]   bOp_r;
  logic [WIDTH-1:0]   upper_r;
  logic [WIDTH-1:0]   lower_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               divByZero_r;

  logic               signA_s;
  logic               signB_s;
  logic [WIDTH-1:0]   magA_s;
  logic [WIDTH-1:0]   magB_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     mulSum_s;
  logic [WIDTH:0]     divShift_s;
  logic [WIDTH+1:0]   divDiff_s;
  logic [WIDTH-1:0]   nextUpper_s;
  logic [WIDTH-1:0]   nextLower_s;
  logic [2*WIDTH-1:0] prodFix_s;
  logic [2*WIDTH-1:0] finalProd_s;
  logic [WIDTH-1:0]   quotFix_s;
  logic [WIDTH-1:0]   remFix_s;

  // Operand sign capture and magnitude conversion at launch (Op[0]=0 means signed).
  always_comb begin
    signA_s = ~Op[0] & inA[WIDTH-1];
    signB_s = ~Op[0] & inB[WIDTH-1];
    magA_s  = negIf(inA, signA_s);
    magB_s  = negIf(inB, signB_s);
  end

  // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts.
  always_comb begin
    addend_s    = lower_r[0] ? bOp_r : '0;
    mulSum_s    = {1'b0, upper_r} + {1'b0, addend_s};
    divShift_s  = {upper_r, lower_r[WIDTH-1]};
    divDiff_s   = {1'b0, divShift_s} - {2'b00, bOp_r};
    nextUpper_s = '0;
    nextLower_s = '0;
    if (isDiv_r) begin
      if (!divDiff_s[WIDTH+1]) begin
        nextUpper_s = divDiff_s[WIDTH-1:0];
        nextLower_s = {lower_r[WIDTH-2:0], 1'b1};
      end else begin
        nextUpper_s = divShift_s[WIDTH-1:0];
        nextLower_s = {lower_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextUpper_s = mulSum_s[WIDTH:1];
      nextLower_s = {mulSum_s[0], lower_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the finished magnitudes; a zero divisor forces an all-ones quotient.
  always_comb begin
    prodFix_s = negIfWide({upper_r, lower_r}, negRes_r);
    remFix_s  = negIf(upper_r, negRem_r);
    if (divZero_r) begin
      quotFix_s = '1;
    end else begin
      quotFix_s = negIf(lower_r, negRes_r);
    end
  end

`ifdef HILO_MULDIV_ACCUM_EN
  logic [2*WIDTH-1:0] accSum_s;
  logic               unusedBits_s;
  assign unusedBits_s = divDiff_s[WIDTH];

  // MADD/MADDU: accumulate the signed-fixed product onto the current {Hi,Lo}.
  always_comb begin
    accSum_s = {hi_r, lo_r} + prodFix_s;
    if (accum_r) begin
      finalProd_s = accSum_s;
    end else begin
      finalProd_s = prodFix_s;
    end
  end
`else
  logic [1:0] unusedBits_s;
  assign unusedBits_s = {Accum, divDiff_s[WIDTH]};

  // Without accumulation the fixed product goes straight to {Hi,Lo}.
  always_comb begin
    finalProd_s = prodFix_s;
  end
`endif

  // Control FSM, iteration datapath and the architectural HI/LO registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      isDiv_r     <= 1'b0;
      accum_r     <= 1'b0;
      negRes_r    <= 1'b0;
      negRem_r    <= 1'b0;
      divZero_r   <= 1'b0;
      bOp_r       <= '0;
      upper_r     <= '0;
      lower_r     <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      divByZero_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      divByZero_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (MtHi) begin
            hi_r <= WriteData;
          end
          if (MtLo) begin
            lo_r <= WriteData;
          end
          if (Start) begin
            isDiv_r   <= Op[1];
            accum_r   <= Accum & ~Op[1];
            negRes_r  <= signA_s ^ signB_s;
            upper_r   <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b1;
            state_r   <= RUN;
            if (Op[1]) begin
              bOp_r     <= magB_s;
              lower_r   <= magA_s;
              negRem_r  <= signA_s;
              divZero_r <= (inB == '0);
            end else begin
              bOp_r     <= magA_s;
              lower_r   <= magB_s;
              negRem_r  <= 1'b0;
              divZero_r <= 1'b0;
            end
          end
        end
        RUN: begin
          upper_r <= nextUpper_s;
          lower_r <= nextLower_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          if (isDiv_r) begin
            hi_r        <= remFix_s;
            lo_r        <= quotFix_s;
            divByZero_r <= divZero_r;
          end else begin
            {hi_r, lo_r} <= finalProd_s;
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Hi        = hi_r;
  assign Lo        = lo_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign DivByZero = divByZero_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: latency-scoreboard model plus directed literal checks.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic        Accum = 1'b0;
  logic [31:0] inA = 32'h0;
  logic [31:0] inB = 32'h0;
  logic        MtHi = 1'b0;
  logic        MtLo = 1'b0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, DivByZero;

  int nCmp = 0;
  int nFail = 0;
  bit chkEn = 1'b0;

`ifdef HILO_MULDIV_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .Accum(Accum),
    .inA(inA), .inB(inB), .MtHi(MtHi), .MtLo(MtLo), .WriteData(WriteData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {hi,lo} result of one operation from plain integer math.
  function automatic void calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [63:0] r, output logic dbz);
    longint sa, sb, q, m;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    r   = 64'h0;
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) begin
          r = {a, 32'hFFFFFFFF}; dbz = 1'b1;
        end else begin
          q = sa / sb; m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) begin
          r = {a, 32'hFFFFFFFF}; dbz = 1'b1;
        end else begin
          r = {a % b, a / b};
        end
      end
    endcase
  endfunction

  logic [31:0] mHi, mLo;
  logic        mBusy, mDone, mDbz;
  int          pend;
  logic [63:0] pendRes;
  logic        pendDbz, pendAcc;

  // Model: result computed at launch and released WIDTH+1 edges later.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mHi = 32'h0; mLo = 32'h0; mBusy = 1'b0; mDone = 1'b0; mDbz = 1'b0;
      pend = 0; pendRes = 64'h0; pendDbz = 1'b0; pendAcc = 1'b0;
    end else begin
      mDone = 1'b0; mDbz = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pendAcc) {mHi, mLo} = {mHi, mLo} + pendRes;
          else         {mHi, mLo} = pendRes;
          mDone = 1'b1; mDbz = pendDbz; mBusy = 1'b0;
        end
      end else begin
        if (MtHi) mHi = WriteData;
        if (MtLo) mLo = WriteData;
        if (Start) begin
          calc(Op, inA, inB, pendRes, pendDbz);
          pendAcc = ACC_EN && Accum && !Op[1];
          pend = 33;
          mBusy = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chkEn) begin
      cmp("Hi", Hi, mHi);
      cmp("Lo", Lo, mLo);
      cmp("Busy", {31'h0, Busy}, {31'h0, mBusy});
      cmp("Done", {31'h0, Done}, {31'h0, mDone});
      cmp("DivByZero", {31'h0, DivByZero}, {31'h0, mDbz});
    end
  end

  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic acc);
    @(posedge Clk); #2;
    Start = 1'b1; Op = op; inA = a; inB = b; Accum = acc;
    @(posedge Clk); #2;
    Start = 1'b0; Accum = 1'b0;
  endtask

  task automatic mtWrite(input logic hiEn, input logic loEn, input logic [31:0] d);
    @(posedge Clk); #2;
    MtHi = hiEn; MtLo = loEn; WriteData = d;
    @(posedge Clk); #2;
    MtHi = 1'b0; MtLo = 1'b0;
  endtask

  task automatic waitDone(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if (Done) got = 1'b1;
    end
    nCmp++;
    if (!got) begin
      nFail++;
      $display("FAIL %s: Done never rose within 40 cycles", nm);
    end
  endtask

  task automatic runOp(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
    startOp(op, a, b, 1'b0);
    waitDone(nm);
    cmp({nm, ".Hi"}, Hi, expHi);
    cmp({nm, ".Lo"}, Lo, expLo);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    #2 chkEn = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    cmp("rst.Hi", Hi, 32'h0);
    cmp("rst.Busy", {31'h0, Busy}, 32'h0);
    @(posedge Clk); #2 Reset_n = 1'b1;

    runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runOp("mult_neg", 2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("mult_nn", 2'b00, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h0, 32'd12);
    runOp("div_negdiv", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    runOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    runOp("divu_16", 2'b11, 32'hFFFFFFFF, 32'd16, 32'hF, 32'h0FFFFFFF);
    runOp("div_zero_s", 2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    runOp("divu_zero", 2'b11, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF);
    cmp("divu_zero.flag", {31'h0, DivByZero}, 32'h1);
    @(negedge Clk);
    cmp("divu_zero.flag_off", {31'h0, DivByZero}, 32'h0);

    // Start and MtHi during Busy are both dropped.
    startOp(2'b01, 32'd5, 32'd6, 1'b0);
    repeat (8) @(posedge Clk);
    #2; Start = 1'b1; Op = 2'b11; inA = 32'd9; inB = 32'd2; MtHi = 1'b1; WriteData = 32'h1234;
    @(posedge Clk); #2; Start = 1'b0; MtHi = 1'b0;
    waitDone("busy_ignore");
    cmp("busy_ignore.Hi", Hi, 32'h0);
    cmp("busy_ignore.Lo", Lo, 32'd30);
    mtWrite(1'b0, 1'b1, 32'hAA);
    #1 cmp("mtlo_idle", Lo, 32'hAA);

    // Reset mid-divide discards everything.
    startOp(2'b10, 32'd1000, 32'd7, 1'b0);
    repeat (13) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    cmp("midrst.Busy", {31'h0, Busy}, 32'h0);
    cmp("midrst.Lo", Lo, 32'h0);
    cmp("midrst.Hi", Hi, 32'h0);
    @(posedge Clk); #2 Reset_n = 1'b1;
    runOp("after_rst", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6);

    // Accumulate request: base loaded with both move-to writes in one cycle.
    mtWrite(1'b1, 1'b1, 32'd0);
    mtWrite(1'b0, 1'b1, 32'd10);
    startOp(2'b01, 32'd4, 32'd5, 1'b1);
    waitDone("accum");
    cmp("accum.Hi", Hi, 32'h0);
    cmp("accum.Lo", Lo, ACC_EN ? 32'd30 : 32'd20);

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
